// File: rtl/alu_mc.sv
// alu_mc: registered, multi-cycle ALU that sits between the register file /
// accumulator and the writeback mux.
//
// Single-cycle ops (ADD, SUB, SLL, SRL, EQU, GTR, AND, XOR, illegal) register
// their result on the accepting edge. MUL is an iterative shift-add that
// needs WIDTH cycles.
//
// Build option: define ALU_MC_MUL_EN to build the MUL datapath. Without it,
// op 8 behaves like any illegal code and busy_out/rslt_hi_out are tied 0.
//
// Ports:
//   clk, rst_n    clock (rising edge), asynchronous active-low reset
//   start         request, sampled only while busy_out=0
//   op_ctrl[3:0]  0 ADD 1 SUB 2 SLL 3 SRL 4 EQU 5 GTR 6 AND 7 XOR 8 MUL
//   reg_in        register-file operand
//   acc_in        accumulator operand
//   rslt_out      registered result (low half of the product for MUL)
//   rslt_hi_out   high half of the MUL product, 0 otherwise
//   zero_out      full result is zero
//   carry_out     ADD carry / SUB borrow, 0 otherwise
//   illegal_out   completed op code was not recognised
//   busy_out      MUL in progress
//   done_out      one-cycle pulse when the outputs were just updated
//
// Handshake: a request is taken on any rising edge where start=1 and
// busy_out=0; there is no queueing, so a start during busy_out=1 is dropped.
// Outputs hold their value between done_out pulses.
module alu_mc #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [3:0]       op_ctrl,
  input  logic [WIDTH-1:0] reg_in,
  input  logic [WIDTH-1:0] acc_in,
  output logic [WIDTH-1:0] rslt_out,
  output logic [WIDTH-1:0] rslt_hi_out,
  output logic             zero_out,
  output logic             carry_out,
  output logic             illegal_out,
  output logic             busy_out,
  output logic             done_out
);

  localparam logic [3:0] OP_ADD = 4'd0;
  localparam logic [3:0] OP_SUB = 4'd1;
  localparam logic [3:0] OP_SLL = 4'd2;
  localparam logic [3:0] OP_SRL = 4'd3;
  localparam logic [3:0] OP_EQU = 4'd4;
  localparam logic [3:0] OP_GTR = 4'd5;
  localparam logic [3:0] OP_AND = 4'd6;
  localparam logic [3:0] OP_XOR = 4'd7;

  localparam logic [WIDTH-1:0] SHAMT_LIM = WIDTH[WIDTH-1:0];

  // Single-cycle result
  logic [WIDTH:0]   sum_c;
  logic [WIDTH:0]   diff_c;
  logic [WIDTH-1:0] res_c;
  logic             carry_c;
  logic             ill_c;

  always_comb begin
    sum_c   = {1'b0, reg_in} + {1'b0, acc_in};
    // Bit WIDTH of the extended difference is the borrow (reg_in < acc_in).
    diff_c  = {1'b0, reg_in} - {1'b0, acc_in};
    res_c   = '0;
    carry_c = 1'b0;
    ill_c   = 1'b0;
    case (op_ctrl)
      OP_ADD: begin res_c = sum_c[WIDTH-1:0];  carry_c = sum_c[WIDTH];  end
      OP_SUB: begin res_c = diff_c[WIDTH-1:0]; carry_c = diff_c[WIDTH]; end
      OP_SLL: res_c = (reg_in >= SHAMT_LIM) ? '0 : (acc_in << reg_in);
      OP_SRL: res_c = (reg_in >= SHAMT_LIM) ? '0 : (acc_in >> reg_in);
      OP_EQU: res_c = {{(WIDTH-1){1'b0}}, (reg_in == acc_in)};
      OP_GTR: res_c = {{(WIDTH-1){1'b0}}, (reg_in > acc_in)};
      OP_AND: res_c = reg_in & acc_in;
      OP_XOR: res_c = reg_in ^ acc_in;
      default: ill_c = 1'b1;
    endcase
  end

  // Values to be loaded into the output registers
  logic             out_load;
  logic [WIDTH-1:0] out_lo;
  logic [WIDTH-1:0] out_hi;
  logic             out_carry;
  logic             out_ill;

`ifdef ALU_MC_MUL_EN
  localparam logic [3:0] OP_MUL = 4'd8;
  localparam int CNT_W = $clog2(WIDTH) + 1;
  // The accepting edge already performs the first step, so the MUL state
  // runs WIDTH-1 steps; the last one happens when cnt_q is WIDTH-2 and
  // the counter reaches WIDTH-1.
  localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 2);

  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   mcand_q;
  // {product_hi, multiplier/product_lo}: the multiplier is consumed from the
  // LSB while product bits shift in from the top.
  logic [2*WIDTH-1:0] prod_q;

  logic [2*WIDTH-1:0] step_src;
  logic [WIDTH-1:0]   step_mcand;
  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] step_res;

  always_comb begin
    step_src   = (state_q == S_IDLE) ? {{WIDTH{1'b0}}, reg_in} : prod_q;
    step_mcand = (state_q == S_IDLE) ? acc_in : mcand_q;
    step_sum   = {1'b0, step_src[2*WIDTH-1:WIDTH]}
               + ({(WIDTH+1){step_src[0]}} & {1'b0, step_mcand});
    step_res   = {step_sum, step_src[WIDTH-1:1]};
  end

  always_comb begin
    state_d   = state_q;
    out_load  = 1'b0;
    out_lo    = res_c;
    out_hi    = '0;
    out_carry = carry_c;
    out_ill   = ill_c;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          if (op_ctrl == OP_MUL) state_d  = S_MUL;
          else                   out_load = 1'b1;
        end
      end
      S_MUL: begin
        if (cnt_q == LAST_STEP) begin
          state_d   = S_IDLE;
          out_load  = 1'b1;
          out_lo    = step_res[WIDTH-1:0];
          out_hi    = step_res[2*WIDTH-1:WIDTH];
          out_carry = 1'b0;
          out_ill   = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mcand_q <= '0;
      prod_q  <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_IDLE) begin
        if (start && (op_ctrl == OP_MUL)) begin
          mcand_q <= acc_in;
          prod_q  <= step_res;
          cnt_q   <= '0;
        end
      end else begin
        prod_q <= step_res;
        cnt_q  <= cnt_q + 1'b1;
      end
    end
  end

  assign busy_out = (state_q == S_MUL);
`else
  always_comb begin
    out_load  = start;
    out_lo    = res_c;
    out_hi    = '0;
    out_carry = carry_c;
    out_ill   = ill_c;
  end

  assign busy_out = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rslt_out    <= '0;
      rslt_hi_out <= '0;
      zero_out    <= 1'b0;
      carry_out   <= 1'b0;
      illegal_out <= 1'b0;
      done_out    <= 1'b0;
    end else begin
      done_out <= out_load;
      if (out_load) begin
        rslt_out    <= out_lo;
        rslt_hi_out <= out_hi;
        zero_out    <= ({out_hi, out_lo} == '0);
        carry_out   <= out_carry;
        illegal_out <= out_ill;
      end
    end
  end

endmodule
